// File: rtl/pe_psum_drain.sv
// Receive end of the systolic array: de-skews the last-row partial sums into
// an N x N tile and streams it out as packed 32-bit words over valid/ready.
module pe_psum_drain #(
   parameter int num_cols_p   = 4,
   parameter int psum_width_p = 16
) (
   input  logic                               clk_i,
   input  logic                               reset,
   input  logic                               start_i,
   input  logic [num_cols_p*psum_width_p-1:0] psum_i,
   output logic                               v_o,
   output logic [31:0]                        data_o,
   input  logic                               ready_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               error_o
);

   localparam int N  = num_cols_p;
   localparam int HP = N / 2;
   localparam int NW = N * N / 2;
   localparam int CW = $clog2(2 * N);
   localparam int WW = $clog2(NW);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_SEND
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nx;
   logic [CW-1:0]           r_cnt;
   logic [WW-1:0]           r_w;
   logic                    r_done;
   logic                    r_err;
   logic [psum_width_p-1:0] r_buf [N][N];

   logic                    w_xfer;
   logic                    w_last;
   logic                    w_cap;
   logic [CW-1:0]           w_c;
   logic [31:0]             w_data;

   assign v_o     = (r_state == S_SEND);
   assign busy_o  = (r_state != S_IDLE);
   assign done_o  = r_done;
   assign error_o = r_err;
   assign w_xfer  = v_o & ready_i;
   assign w_last  = (r_w == WW'(NW - 1));

   // Capture cycle 0 is the start edge itself, before the counter is loaded.
   assign w_cap = ((r_state == S_IDLE) & start_i) | (r_state == S_CAPTURE);
   assign w_c   = (r_state == S_IDLE) ? '0 : r_cnt;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:    if (start_i) w_state_nx = S_CAPTURE;
         S_CAPTURE: if (r_cnt == CW'(2 * N - 2)) w_state_nx = S_SEND;
         S_SEND:    if (w_xfer && w_last) w_state_nx = S_IDLE;
         default:   w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_w     <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_done  <= w_xfer & w_last;
         if (start_i && r_state != S_IDLE) r_err <= 1'b1;
         if (r_state == S_IDLE && start_i) r_cnt <= CW'(1);
         else if (r_state == S_CAPTURE) r_cnt <= r_cnt + CW'(1);
         if (r_state == S_CAPTURE) r_w <= '0;
         else if (w_xfer) r_w <= r_w + WW'(1);
      end
   end

   // Column j holds row (c - j) during capture cycle c.
   always_ff @(posedge clk_i) begin
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) begin
            if (w_cap && int'(w_c) == r + j)
               r_buf[r][j] <= psum_i[psum_width_p*j +: psum_width_p];
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int r = 0; r < N; r++) begin
         for (int k = 0; k < HP; k++) begin
            if (int'(r_w) == r * HP + k)
               w_data = {r_buf[r][2*k], r_buf[r][2*k+1]};
         end
      end
   end

   assign data_o = v_o ? w_data : 32'h0;

endmodule

// File: tb/tb_pe_psum_drain.sv
// Directed bench for pe_psum_drain (N=4): skewed lane stimulus, word
// scoreboard, backpressure, busy-start errors, mid-tile reset, back-to-back.
module tb_pe_psum_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [63:0] psum_i;
   logic        v_o;
   logic [31:0] data_o;
   logic        ready_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   int          n_chk = 0;
   int          n_fail = 0;
   int          n_xfer = 0;
   int          cap_c = -1;
   logic [15:0] cap_off = 16'h0;
   logic [31:0] exp_q[$];
   logic        stalled = 1'b0;
   logic [31:0] held = 32'h0;
   int          k;

   pe_psum_drain #(.num_cols_p(4), .psum_width_p(16)) dut (
      .clk_i   (clk),
      .reset   (reset),
      .start_i (start_i),
      .psum_i  (psum_i),
      .v_o     (v_o),
      .data_o  (data_o),
      .ready_i (ready_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .error_o (error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_psum();
      for (int j = 0; j < 4; j++) begin
         int d;
         d = cap_c - j;
         if (cap_c >= 0 && d >= 0 && d <= 3)
            psum_i[16*j +: 16] = 16'h0100 + cap_off + 16'(16 * d + j);
         else
            psum_i[16*j +: 16] = 16'hDEAD;
      end
   endtask

   // Inputs are already set for the coming edge; observe, then advance.
   task automatic tick();
      drive_psum();
      if (stalled) begin
         chk("hold_v", 32'(v_o), 32'd1);
         chk("hold_data", data_o, held);
      end
      if (v_o && ready_i) begin
         n_xfer++;
         n_chk++;
         assert (exp_q.size() > 0)
         else begin
            n_fail++;
            $error("FAIL extra_word observed=%h expected=none", data_o);
         end
         if (exp_q.size() > 0) chk("word", data_o, exp_q.pop_front());
      end
      stalled = v_o && !ready_i;
      held    = data_o;
      @(posedge clk);
      #1;
      if (cap_c >= 0) cap_c = (cap_c == 6) ? -1 : cap_c + 1;
   endtask

   task automatic start_tile(input logic [15:0] off);
      cap_c   = 0;
      cap_off = off;
      n_xfer  = 0;
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < 2; p++)
            exp_q.push_back({16'h0100 + off + 16'(16 * r + 2 * p),
                             16'h0100 + off + 16'(16 * r + 2 * p + 1)});
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic busy_pulse();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (!done_o && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done_o), 32'd1);
      chk("done_v_low", 32'(v_o), 32'd0);
      chk("done_idle", 32'(busy_o), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_xfer(input int target, input int budget);
      int n;
      n = 0;
      while (n_xfer < target && n < budget) begin
         tick();
         n++;
      end
      chk("xfer_reached", 32'(n_xfer), 32'(target));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      exp_q.delete();
      cap_c   = -1;
      stalled = 1'b0;
      chk("rst_v", 32'(v_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(error_o), 32'd0);
   endtask

   task automatic clean_tile(input string tag);
      start_tile(16'h0);
      wait_done(40, k);
      chk(tag, 32'(k), 32'd14);
      chk("clean_xfers", 32'(n_xfer), 32'd8);
      chk("clean_err", 32'(error_o), 32'd0);
      tick();
   endtask

   initial begin
      reset   = 1'b1;
      start_i = 1'b0;
      ready_i = 1'b1;
      psum_i  = '1;
      tick();
      do_reset();

      // Basic tile with latency and pulse width checks.
      start_tile(16'h0);
      chk("busy_rise", 32'(busy_o), 32'd1);
      chk("v_after_start", 32'(v_o), 32'd0);
      for (int i = 0; i < 5; i++) tick();
      chk("v_before_lat", 32'(v_o), 32'd0);
      tick();
      chk("v_at_lat", 32'(v_o), 32'd1);
      chk("first_word", data_o, 32'h01000101);
      wait_done(20, k);
      chk("send_cycles", 32'(k), 32'd8);
      chk("basic_xfers", 32'(n_xfer), 32'd8);
      tick();
      chk("done_one_cycle", 32'(done_o), 32'd0);
      chk("basic_err", 32'(error_o), 32'd0);

      // Backpressure: stall 3 cycles at word 2, then alternate.
      start_tile(16'h0);
      wait_xfer(2, 20);
      chk("stall_word", data_o, 32'h01100111);
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("stall_still", data_o, 32'h01100111);
      k = 0;
      while (!done_o && k < 40) begin
         ready_i = ~ready_i;
         tick();
         k++;
      end
      chk("bp_done", 32'(done_o), 32'd1);
      chk("bp_xfers", 32'(n_xfer), 32'd8);
      chk("bp_queue", 32'(exp_q.size()), 32'd0);
      ready_i = 1'b1;
      tick();

      // Start while busy: in CAPTURE c=3 and at SEND word 5.
      start_tile(16'h0);
      tick();
      tick();
      busy_pulse();
      chk("err_capture", 32'(error_o), 32'd1);
      wait_xfer(5, 20);
      busy_pulse();
      chk("err_send", 32'(error_o), 32'd1);
      wait_done(20, k);
      chk("busy_start_xfers", 32'(n_xfer), 32'd8);
      for (int i = 0; i < 10; i++) tick();
      chk("no_extra_tile", 32'(n_xfer), 32'd8);
      chk("err_sticky", 32'(error_o), 32'd1);

      // Reset during CAPTURE c=4.
      start_tile(16'h0);
      for (int i = 0; i < 3; i++) tick();
      chk("at_c4", 32'(cap_c), 32'd4);
      do_reset();
      tick();
      chk("no_done_cap", 32'(done_o), 32'd0);
      clean_tile("after_cap_reset");

      // Reset during SEND word 3.
      start_tile(16'h0);
      wait_xfer(3, 20);
      do_reset();
      tick();
      chk("no_done_send", 32'(done_o), 32'd0);
      chk("no_v_send", 32'(v_o), 32'd0);
      clean_tile("after_send_reset");

      // Back-to-back with start in the done cycle.
      start_tile(16'h0);
      wait_done(40, k);
      start_tile(16'h0200);
      chk("b2b_busy", 32'(busy_o), 32'd1);
      wait_done(40, k);
      chk("b2b_cycles", 32'(k), 32'd14);
      chk("b2b_xfers", 32'(n_xfer), 32'd8);
      chk("b2b_err", 32'(error_o), 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pe_psum_drain.md
# pe_psum_drain

Output-side endpoint of the torus systolic array. It captures the skewed `Partial_Sum_out` lanes leaving the array's last PE row, de-skews them into an N×N result tile, and streams the tile to the host/trace side as packed 32-bit words over a valid/ready interface. This is the receive end of the PE data path: the block consumes what the PEs emit, in the same way the operand feeder produces what they consume.

## Interface
Parameters:
- `num_cols_p`, 4: array columns, which is also the tile dimension N. Must be even and ≥2.
- `psum_width_p`, 16: width of each partial-sum lane. Fixed at 16 so that two lanes pack into one word.

Ports:
- `clk_i`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle pulse that marks capture cycle 0 of a tile.
- `psum_i`  in  num_cols_p*16  lane j = `psum_i[16*j +: 16]`, taken from `Partial_Sum_out` of column j.
- `v_o`  out  1  `data_o` holds a valid word.
- `data_o`  out  32  packed word: `{psum[r][2k], psum[r][2k+1]}`, with the even column in bits [31:16].
- `ready_i`  in  1  consumer accepts; a transfer occurs when `v_o & ready_i`.
- `busy_o`  out  1  high in CAPTURE and SEND.
- `done_o`  out  1  one-cycle pulse after the last word of a tile transfers.
- `error_o`  out  1  sticky; set when `start_i` arrives while busy. Cleared only by reset.

## Operation
- States: IDLE, CAPTURE, SEND.
- **IDLE**
  - `start_i` → CAPTURE.
  - `psum_i` is sampled on the same edge as capture cycle c=0.
  - The capture counter is set to 1.
- **CAPTURE** (cycles c = 0 .. 2N−2)
  - For each column j, when 0 ≤ c−j ≤ N−1, write `psum_i` lane j into `buf[c−j][j]`. All other lanes are ignored.
  - Column j therefore contributes rows 0..N−1 in cycles j..j+N−1.
  - After the c = 2N−2 sample, go to SEND with word index 0.
- **SEND**
  - Emit N*N/2 words in row-major order: word w gives row r = w/(N/2), pair k = w mod (N/2).
  - On each transfer, w increments.
  - On the transfer of the last word, go to IDLE and pulse `done_o` in the following cycle.
- **Backpressure:** while `v_o & ~ready_i`, `data_o` and `v_o` hold stable. The word index never advances without a transfer.
- **Start while busy:** `start_i` in CAPTURE or SEND is ignored and sets `error_o`. The current tile continues unaffected.
- **Start during the done cycle:** `start_i` in the cycle `done_o` is high (state IDLE) is accepted normally.
- **Arithmetic:** psums are passed through unmodified. No sign extension and no arithmetic is applied.
- **Buffer:** N×N×16 flops. Contents are undefined after reset and must never be emitted before a full capture.

## Timing
- **Reset values:** state IDLE. `v_o`, `data_o`, `busy_o`, `done_o` and `error_o` are all 0 in the cycle after reset is sampled high.
- **Reset mid-operation** (CAPTURE or SEND):
  - The tile is abandoned.
  - Outputs go to reset values on the next cycle.
  - No `done_o` is issued.
- `busy_o` rises in the cycle after `start_i` is sampled and falls together with the entry to IDLE.
- **Capture window:** `start_i` is sampled at edge E0, and capture samples occur at edges E0..E0+2N−2 (2N−1 edges).
- **Output latency:** `v_o` first rises in the cycle after edge E0+2N−2, i.e. 2N−1 cycles after `start_i`.
- **Throughput:** one word per cycle with `ready_i` held high, so a tile completes in N*N/2 consecutive cycles.
- **Done pulse:** `done_o` is high for exactly one cycle, the cycle after the final transfer. `v_o` is 0 in that cycle.
- **Turnaround:** minimum start-to-start interval is (2N−1) + N*N/2 cycles.

## Test plan
All scenarios use N=4. The stimulus drives lane j with `0x0100 + 16*r + j` in cycle c = r+j and with `0xDEAD` outside each lane's window.

1. **Basic tile**, `ready_i`=1 → `v_o` rises 7 cycles after `start_i`. The 8 words are `0x01000101, 0x01020103, 0x01100111, … , 0x01320133` on consecutive cycles, and `done_o` follows one cycle later. No `0xDEAD` appears.
2. **Backpressure:** drop `ready_i` for 3 cycles at word 2 and then alternate 1/0 → `data_o` holds `0x01100111` while stalled. Exactly 8 transfers occur, in order.
3. **Start while busy:** pulse `start_i` in CAPTURE c=3 and again at SEND word 5 → `error_o` rises and stays 1. Output is the same as scenario 1 with no extra tile.
4. **Reset mid-operation:** assert reset at CAPTURE c=4 and, in a separate run, at SEND word 3 → all outputs are 0 the next cycle. A fresh `start_i` afterwards produces a clean scenario-1 tile with `error_o`=0.
5. **Back-to-back:** second `start_i` in the `done_o` cycle, second tile = first + 0x0200 → 16 correct words total. `error_o` stays 0.
